// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the single-cycle core.
// Turns a load/store from the control unit into one req/ack transfer on the
// data-memory bus. It stalls the core until the bus answers or the access
// times out. Load data comes back lane-extracted and sign/zero-extended.
//
// Handshake: bus_req is raised in REQ with bus_addr/bus_we/bus_be/bus_wdata
// already stable, and is held until bus_ack is sampled high on a rising edge
// (transfer done; bus_rdata is valid on that same edge) or until TIMEOUT REQ
// cycles pass without an ack. bus_ack is ignored in every other state.
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        access_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_timeout;
    logic [2:0]     r_funct3;
    logic [1:0]     r_lane;
    logic [31:0]    r_rdata;
    logic [31:0]    r_bus_addr;
    logic [31:0]    r_bus_wdata;
    logic [3:0]     r_bus_be;
    logic           r_bus_we;

    logic           w_access;
    logic           w_illegal;
    logic           w_issue;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [CW-1:0]  w_cnt_inc;
    logic           w_expire;
    logic [31:0]    w_shifted;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load;

    assign w_access  = mem_read | mem_write;
    assign w_issue   = (r_state == S_IDLE) & w_access & ~w_illegal;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_expire  = (w_cnt_inc == CW'(TIMEOUT));

    // Legality: conflicting request, undefined size code, misalignment,
    // or an unsigned size code on a store.
    always_comb begin
        w_illegal = mem_read & mem_write;
        case (funct3)
            3'b000: ;
            3'b001: if (addr[0]) w_illegal = 1'b1;
            3'b010: if (addr[1:0] != 2'b00) w_illegal = 1'b1;
            3'b100: if (mem_write) w_illegal = 1'b1;
            3'b101: if (addr[0] | mem_write) w_illegal = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data for the requested size.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        w_shifted = bus_rdata >> {r_lane, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state plus the combinational handshake/stall outputs.
    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        access_err = 1'b0;
        bus_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    stall  = 1'b1;
                    w_next = S_REQ;
                end else if (w_access) begin
                    access_err = 1'b1;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                if (bus_ack || w_expire) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the request on issue, count wait cycles, capture the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_rdata     <= 32'd0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'b0000;
            r_bus_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_wdata <= mem_write ? w_wdata : 32'd0;
                        r_bus_be    <= w_be;
                        r_bus_we    <= mem_write;
                        r_funct3    <= funct3;
                        r_lane      <= addr[1:0];
                        r_cnt       <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_rdata <= r_bus_we ? 32'd0 : w_load;
                        r_cnt   <= '0;
                    end else if (w_expire) begin
                        r_rdata   <= 32'd0;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    r_rdata   <= 32'd0;
                    r_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign bus_err   = r_timeout;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign dbg_state = r_state;

endmodule
